equiv_monitor: RTL
==================

# equiv_monitor

Downstream checking stage for the equivalence harness. Consumes the two 91-bit result vectors produced by the paired design instances and compares them cycle by cycle over a bounded run. It replaces the bare per-cycle assertion with a reset-able, start-triggered checker. The checker skips a warm-up window in which instance registers are still settling, counts mismatches, captures the first failing cycle and its difference vector, and reports pass/fail.

## Interface
- WIDTH, 91: width of compared result vectors.
- WARMUP, 4: cycles after start during which comparison is suppressed; 0 is legal.
- RUN_CYCLES, 1024: number of compared cycles per run; must be ≥1.
- CNT_W, 16: width of all counters and cycle indices.
- STOP_ON_FAIL, 1: 1 = end run on first mismatch; 0 = run full length.

Ports:
- clk  in  1  rising-edge clock, shared with the design instances.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run.
- y_1  in  WIDTH  result of instance 1.
- y_2  in  WIDTH  result of instance 2.
- busy  out  1  high in WARMUP or CHECK.
- done  out  1  high in DONE.
- fail  out  1  sticky; at least one mismatch in the current run.
- mismatch_cnt  out  CNT_W  mismatching compared cycles; saturating.
- cycle_cnt  out  CNT_W  compared cycles completed in the current run.
- first_fail_cycle  out  CNT_W  0-based compare index of the first mismatch.
- first_diff  out  WIDTH  y_1 ^ y_2 at the first mismatch.

## Operation
- FSM states (shared enum): IDLE, WARMUP, CHECK, DONE.
- Reset (async, any state): state = IDLE. All outputs and counters = 0.
- IDLE:
  - start goes to WARMUP if WARMUP>0, otherwise to CHECK.
  - On that edge, clear fail, mismatch_cnt, cycle_cnt, first_fail_cycle, first_diff, and the warm-up counter.
- WARMUP:
  - The warm-up counter increments each cycle.
  - After exactly WARMUP cycles in WARMUP, go to CHECK.
  - y_1 and y_2 are ignored.
- CHECK, at every rising edge:
  - Compute mis = (y_1 != y_2), full-width compare, and increment cycle_cnt.
  - If mis and fail==0: capture first_fail_cycle = cycle_cnt (pre-increment value) and first_diff = y_1 ^ y_2, and set fail.
  - If mis: mismatch_cnt increments, holding at 2^CNT_W−1 once reached.
  - If mis and STOP_ON_FAIL: go to DONE on this edge. The failing cycle is counted.
  - Otherwise, go to DONE on the edge where pre-increment cycle_cnt == RUN_CYCLES−1.
- DONE:
  - All result outputs hold.
  - start behaves exactly as in IDLE: clear results and begin a new run.
- start while busy is ignored.
- X/Z on y inputs counts as a mismatch. In simulation use the case-inequality sense, so X never silently passes.

## Timing
- Outputs are registered. No combinational path from y_1/y_2 or start to any output.
- Comparison latency is 1 cycle: the mismatch sampled at edge k is visible on the outputs after edge k.
- start at edge s:
  - busy rises after edge s.
  - The first compare happens at edge s+WARMUP+1.
- Run length:
  - Clean run: done rises after edge s+WARMUP+RUN_CYCLES.
  - Early stop: done rises after the failing edge.
- done and busy are never high together. Neither is high in IDLE.
- Mismatch on the final compared cycle: it is recorded and the run ends normally on that same edge.
- rst_n deasserting mid-run aborts the run. Nothing is retained.
- Reset release is synchronised externally. The block needs no recovery logic beyond the async clear.

## Structure
- Package equiv_pkg holds:
  - the state enum type equiv_state_t (IDLE, WARMUP, CHECK, DONE);
  - default constants for WIDTH (91) and CNT_W (16).
- One sub-module is natural: sat_counter (parameter W, with clear/inc inputs), used for mismatch_cnt.
- cycle_cnt and the warm-up counter are plain counters and stay inline.

## Test plan
- Equal vectors: WARMUP=4, RUN_CYCLES=8, y_1=y_2=constant. start → done after 12 cycles, fail=0, mismatch_cnt=0, cycle_cnt=8.
- Mismatches hidden in warm-up: mismatches only during the 4 warm-up cycles, then equal. Result fail=0, mismatch_cnt=0.
- Early stop: STOP_ON_FAIL=1, y_2 = y_1 ^ (1<<90) on compare index 3. Result:
  - done 4 cycles after the first compare;
  - first_fail_cycle=3, first_diff=1<<90;
  - mismatch_cnt=1, cycle_cnt=4.
- Full run with failures: STOP_ON_FAIL=0, mismatches at indices 2 and 5 of 8.
  - first_fail_cycle=2 and first_diff reflects index 2 only.
  - mismatch_cnt=2, cycle_cnt=8.
- Counter saturation: CNT_W=4, RUN_CYCLES=20, every cycle mismatching, STOP_ON_FAIL=0. Result mismatch_cnt=15 held, done asserted.
- Reset and restart: rst_n pulsed low mid-CHECK clears all outputs immediately. start pulsed during busy is ignored. start in DONE clears the results and starts a new run.

Source files
------------

// File: rtl/equiv_pkg.sv
// rtl/equiv_pkg.sv - shared state type and default widths for the equivalence checker
package equiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    CHECK,
    DONE
  } equiv_state_t;

  localparam int EQ_WIDTH = 91;
  localparam int EQ_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that clears on request and holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/equiv_monitor.sv
// rtl/equiv_monitor.sv - start-triggered checker comparing two result vectors over a bounded run
module equiv_monitor
  import equiv_pkg::*;
#(
  parameter int WIDTH        = EQ_WIDTH,
  parameter int WARMUP       = 4,
  parameter int RUN_CYCLES   = 1024,
  parameter int CNT_W        = EQ_CNT_W,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] y_1,
  input  logic [WIDTH-1:0] y_2,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] first_fail_cycle,
  output logic [WIDTH-1:0] first_diff
);

  // The run index may need more bits than CNT_W so the end-of-run test never aliases.
  localparam int RUN_W = $clog2(RUN_CYCLES + 1);
  localparam int IDX_W = (CNT_W > RUN_W) ? CNT_W : RUN_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WU_LAST  = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  equiv_state_t     state_q, state_d;
  logic [CNT_W-1:0] wu_q, wu_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] ffc_q, ffc_d;
  logic [WIDTH-1:0] fd_q, fd_d;
  logic             mis;
  logic             launch;

  // Case inequality keeps X/Z from ever comparing equal in simulation.
  assign mis    = (y_1 !== y_2);
  assign launch = start && ((state_q == equiv_pkg::IDLE) || (state_q == equiv_pkg::DONE));

  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    ffc_d   = ffc_q;
    fd_d    = fd_q;
    case (state_q)
      equiv_pkg::IDLE, equiv_pkg::DONE: begin
        if (start) begin
          state_d = (WARMUP > 0) ? equiv_pkg::WARMUP : equiv_pkg::CHECK;
          wu_d    = '0;
          idx_d   = '0;
          fail_d  = 1'b0;
          ffc_d   = '0;
          fd_d    = '0;
        end
      end
      equiv_pkg::WARMUP: begin
        wu_d = wu_q + CNT_W'(1);
        if (wu_q == WU_LAST) begin
          state_d = equiv_pkg::CHECK;
        end
      end
      equiv_pkg::CHECK: begin
        idx_d = idx_q + IDX_W'(1);
        if (mis && !fail_q) begin
          fail_d = 1'b1;
          ffc_d  = idx_q[CNT_W-1:0];
          fd_d   = y_1 ^ y_2;
        end
        if ((mis && STOP_ON_FAIL) || (idx_q == IDX_LAST)) begin
          state_d = equiv_pkg::DONE;
        end
      end
      default: state_d = equiv_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= equiv_pkg::IDLE;
      wu_q    <= '0;
      idx_q   <= '0;
      fail_q  <= 1'b0;
      ffc_q   <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      wu_q    <= wu_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      ffc_q   <= ffc_d;
      fd_q    <= fd_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_mismatch_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (launch),
    .inc  ((state_q == equiv_pkg::CHECK) && mis),
    .cnt  (mismatch_cnt)
  );

  assign busy             = (state_q == equiv_pkg::WARMUP) || (state_q == equiv_pkg::CHECK);
  assign done             = (state_q == equiv_pkg::DONE);
  assign fail             = fail_q;
  assign cycle_cnt        = idx_q[CNT_W-1:0];
  assign first_fail_cycle = ffc_q;
  assign first_diff       = fd_q;

endmodule
